// File: rtl/harness_pkg.sv
// Shared harness definitions: capture-FSM state encoding and the signature rotate helper.
package harness_pkg;

  localparam int unsigned ROT_MAXW = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } harness_state_e;

  // Rotate left by one within the low w bits; callers zero-extend and truncate around it.
  function automatic logic [ROT_MAXW-1:0] rotl1(input logic [ROT_MAXW-1:0] x, input int unsigned w);
    logic [ROT_MAXW-1:0] mask_s;
    mask_s = (w >= ROT_MAXW) ? {ROT_MAXW{1'b1}} : ((ROT_MAXW'(1'b1) << w) - ROT_MAXW'(1'b1));
    return ((x << 1) | (x >> (w - 32'd1))) & mask_s;
  endfunction

endpackage

// File: rtl/harness_rr_arbiter_rr_pick.sv
// Round-robin pick: first valid index searching upward from ptr_i, wrapping at NREQ-1.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  logic [NREQ-1:0] grant_s;
  logic [PW-1:0]   idx_s;
  logic [PW-1:0]   pos_s;
  logic            found_s;
  logic            hit_s;

  // Scan priority order ptr, ptr+1, ... and keep only the first hit.
  always_comb begin
    grant_s = {NREQ{1'b0}};
    idx_s   = {PW{1'b0}};
    pos_s   = {PW{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos_s          = PW'((32'(ptr_i) + k) % NREQ);
      hit_s          = valid_i[pos_s] & ~found_s;
      grant_s[pos_s] = grant_s[pos_s] | hit_s;
      idx_s          = hit_s ? pos_s : idx_s;
      found_s        = found_s | hit_s;
    end
  end

  assign grant_o = grant_s;
  assign idx_o   = idx_s;
  assign any_o   = found_s;

endmodule

// File: rtl/harness_rr_arbiter.sv
// Round-robin capture harness: grants one requester per cycle and folds accepted
// beats into a rotate-XOR signature over a window of WINDOW beats.
module harness_rr_arbiter
  import harness_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned BITS   = 64,
  parameter int unsigned WINDOW = 256
) (
  input  logic                       fast_clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*BITS-1:0]       req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       busy,
  output logic                       done,
  output logic [BITS-1:0]            sig_out,
  output logic [$clog2(WINDOW)-1:0]  beat_cnt
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(WINDOW);

  harness_state_e  state_q;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0] sig_q, sig_d;
  logic            busy_q, done_q;

  logic [NREQ-1:0] grant_s;
  logic [PW-1:0]   gidx_s;
  logic            any_s;
  logic [BITS-1:0] data_s;
  logic            beat_s;
  logic            last_s;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant_s),
    .idx_o   (gidx_s),
    .any_o   (any_s)
  );

  // Grants only in RUN; abort gates acceptance internally so it never reaches an output.
  assign req_ready = (state_q == ST_RUN) ? grant_s : {NREQ{1'b0}};

  // Next-value computation for an accepted beat.
  always_comb begin
    data_s = req_data[32'(gidx_s) * BITS +: BITS];
    beat_s = (state_q == ST_RUN) && any_s && !abort;
    last_s = beat_s && (cnt_q == CW'(WINDOW - 1));
    sig_d  = BITS'(rotl1(ROT_MAXW'(sig_q), BITS)) ^ data_s;
    ptr_d  = (gidx_s == PW'(NREQ - 1)) ? {PW{1'b0}} : gidx_s + PW'(1'b1);
    cnt_d  = last_s ? {CW{1'b0}} : cnt_q + CW'(1'b1);
  end

  // Capture FSM with registered busy/done flags.
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= {PW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      sig_q   <= {BITS{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            ptr_q   <= {PW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            sig_q   <= {BITS{1'b0}};
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (beat_s) begin
            sig_q <= sig_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (last_s) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end else if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ptr_q   <= {PW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            sig_q   <= {BITS{1'b0}};
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign sig_out  = sig_q;
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_harness_rr_arbiter.sv
// Bench for harness_rr_arbiter (NREQ=4, BITS=8, WINDOW=4): directed vectors with literal
// expectations, plus a per-cycle comparison against an abstract window/signature model.
module tb_harness_rr_arbiter;

  localparam int NR  = 4;
  localparam int BW  = 8;
  localparam int WIN = 4;

  logic            fast_clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [NR-1:0]   req_valid;
  logic [NR*BW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            busy;
  logic            done;
  logic [BW-1:0]   sig_out;
  logic [1:0]      beat_cnt;

  int total = 0;
  int bad   = 0;

  // Model: 0 = idle, 1 = capturing, 2 = window complete
  int m_state = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_sig   = 0;

  harness_rr_arbiter #(.NREQ(NR), .BITS(BW), .WINDOW(WIN)) dut (
    .fast_clk  (fast_clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .sig_out   (sig_out),
    .beat_cnt  (beat_cnt)
  );

  always #5 fast_clk = ~fast_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge fast_clk);
    #1;
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic int rot8(input int s);
    return ((s * 2) % 256) + (s / 128);
  endfunction

  function automatic int data_of(input int g);
    return int'(req_data[g*BW +: BW]);
  endfunction

  // Abstract model advanced on every edge
  always @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_ptr <= 0; m_cnt <= 0; m_sig <= 0;
    end else if (m_state == 1) begin
      if (abort) begin
        m_state <= 0;
      end else if (pick(req_valid, m_ptr) >= 0) begin
        m_sig <= rot8(m_sig) ^ data_of(pick(req_valid, m_ptr));
        m_ptr <= (pick(req_valid, m_ptr) + 1) % NR;
        if (m_cnt == WIN - 1) begin
          m_cnt <= 0; m_state <= 2;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (abort && m_state == 2) begin
      m_state <= 0;
    end else if (start) begin
      m_state <= 1; m_ptr <= 0; m_cnt <= 0; m_sig <= 0;
    end
  end

  // Per-cycle comparison, sampled away from the active edge
  always @(negedge fast_clk) begin : cmp
    int g;
    logic [NR-1:0] er;
    g  = pick(req_valid, m_ptr);
    er = (m_state == 1 && g >= 0) ? NR'(1 << g) : '0;
    check("m_ready", 32'(req_ready), 32'(er));
    check("m_busy",  32'(busy),      32'(m_state == 1));
    check("m_done",  32'(done),      32'(m_state == 2));
    check("m_sig",   32'(sig_out),   32'(m_sig));
    check("m_cnt",   32'(beat_cnt),  32'(m_cnt));
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; req_valid = '0; req_data = '0;
    repeat (2) cyc();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sig", 32'(sig_out), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Four requesters, data 01,02,04,08
    req_data = 32'h08040201; req_valid = 4'hF;
    cyc();
    check("idle_ready", 32'(req_ready), 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    check("all_g0", 32'(req_ready), 32'h1);
    check("all_busy", 32'(busy), 32'd1);
    cyc();
    check("all_g1", 32'(req_ready), 32'h2);
    check("all_sig1", 32'(sig_out), 32'h01);
    check("all_cnt1", 32'(beat_cnt), 32'd1);
    repeat (3) cyc();
    check("all_done", 32'(done), 32'd1);
    check("all_sig", 32'(sig_out), 32'h00);
    check("all_cnt", 32'(beat_cnt), 32'd0);
    check("all_rdy_done", 32'(req_ready), 32'd0);
    req_valid = '0;

    // Restart from DONE with nobody valid
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("idle_run_busy", 32'(busy), 32'd1);
      check("idle_run_cnt", 32'(beat_cnt), 32'd0);
      check("idle_run_rdy", 32'(req_ready), 32'd0);
      cyc();
    end

    // Requesters 0 and 3 alternate
    req_data = 32'h30040211; req_valid = 4'b1001;
    #1;
    check("alt_g0", 32'(req_ready), 32'h1);
    cyc(); check("alt_g3", 32'(req_ready), 32'h8);
    cyc(); check("alt_g0b", 32'(req_ready), 32'h1);
    cyc(); check("alt_g3b", 32'(req_ready), 32'h8);
    cyc();
    check("alt_sig", 32'(sig_out), 32'h5A);
    check("alt_done", 32'(done), 32'd1);

    // Only requester 2, data A5
    req_valid = 4'b0100; req_data = 32'h00A50000;
    start = 1'b1; cyc(); start = 1'b0;
    check("one_g2", 32'(req_ready), 32'h4);
    cyc(); check("one_sig1", 32'(sig_out), 32'hA5);
    cyc(); check("one_sig2", 32'(sig_out), 32'hEE);
    check("one_cnt2", 32'(beat_cnt), 32'd2);
    repeat (2) cyc();
    check("one_sig4", 32'(sig_out), 32'h55);
    check("one_done", 32'(done), 32'd1);
    check("one_cnt", 32'(beat_cnt), 32'd0);

    // Abort coinciding with the last beat
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    check("ab_pre_sig", 32'(sig_out), 32'h78);
    check("ab_pre_cnt", 32'(beat_cnt), 32'd3);
    abort = 1'b1; cyc(); abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_sig", 32'(sig_out), 32'h78);
    check("ab_rdy", 32'(req_ready), 32'd0);
    cyc();
    check("ab_done2", 32'(done), 32'd0);

    // Asynchronous reset mid-window
    req_data = 32'h08040301; req_valid = 4'hF;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (2) cyc();
    check("rr_pre_sig", 32'(sig_out), 32'h01);
    check("rr_pre_cnt", 32'(beat_cnt), 32'd2);
    #2; rst_n = 1'b0; #1;
    check("rr_sig", 32'(sig_out), 32'd0);
    check("rr_cnt", 32'(beat_cnt), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_rdy", 32'(req_ready), 32'd0);
    cyc(); rst_n = 1'b1;
    cyc();
    check("rr_noact", 32'(busy), 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    check("rr_new_sig", 32'(sig_out), 32'd0);
    check("rr_new_rdy", 32'(req_ready), 32'h1);
    cyc();
    check("rr_new_sig1", 32'(sig_out), 32'h01);

    req_valid = '0;
    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
